// File: rtl/trng_word_reader.sv
`default_nettype none
// ============================================================================
// Module   : trng_word_reader
// Purpose  : Counts TRNG processed-bit strobes, snapshots each completed
//            32-bit shift-register word into a show-ahead FIFO, and serves
//            words on a valid/ready port with a sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module trng_word_reader #(
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              processed_bit_valid,
    input  logic [WORD_W-1:0] shift_reg,
    input  logic              rd_ready,
    input  logic              clear_overflow,
    output logic              rd_valid,
    output logic [WORD_W-1:0] rd_data,
    output logic [ADDR_W:0]   fifo_level,
    output logic [5:0]        bits_pending,
    output logic              overflow
);

    localparam int              C_LAST_INT   = WORD_W - 1;
    localparam logic [5:0]      C_LAST_BIT   = C_LAST_INT[5:0];
    localparam logic [ADDR_W:0] C_FULL_LEVEL = FIFO_DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] C_LEVEL_ONE  = 1;
    localparam logic [ADDR_W-1:0] C_PTR_ONE  = 1;

    logic [5:0]        cnt_q,    cnt_d;
    logic              cap_q,    cap_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q,  level_d;
    logic              ovf_q,    ovf_d;
    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];

    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign rd_valid = (level_q != '0);
    assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;

    assign w_full = (level_q == C_FULL_LEVEL);
    assign w_pop  = rd_valid & rd_ready;
    // A same-cycle pop frees the head slot, so a full FIFO can still accept.
    assign w_push = cap_q & (~w_full | w_pop);
    assign w_drop = cap_q & w_full & ~w_pop;

    always_comb begin
        cnt_d    = cnt_q;
        cap_d    = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;

        if (!enable) begin
            cnt_d = '0;
        end else if (processed_bit_valid) begin
            if (cnt_q == C_LAST_BIT) begin
                cnt_d = '0;
                cap_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 6'd1;
            end
        end

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + C_PTR_ONE;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + C_PTR_ONE;
        end
        if (w_push && !w_pop) begin
            level_d = level_q + C_LEVEL_ONE;
        end else if (w_pop && !w_push) begin
            level_d = level_q - C_LEVEL_ONE;
        end

        // A drop in the same cycle as a clear request must leave the flag set.
        if (w_drop) begin
            ovf_d = 1'b1;
        end else if (clear_overflow) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            cap_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            cap_q    <= cap_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: entries are only visible through a valid level.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= shift_reg;
        end
    end

    assign fifo_level   = level_q;
    assign bits_pending = cnt_q;
    assign overflow     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_trng_word_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_trng_word_reader
// Purpose  : Self-checking bench for trng_word_reader (vector table plus
//            scoreboard of expected words).
// Revision : 1.0 - initial release
// ============================================================================
module tb_trng_word_reader;

    localparam int WORD_W     = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_W     = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic              processed_bit_valid = 1'b0;
    logic              bit_in = 1'b0;
    logic [WORD_W-1:0] shift_reg;
    logic              rd_ready = 1'b0;
    logic              clear_overflow = 1'b0;
    logic              rd_valid;
    logic [WORD_W-1:0] rd_data;
    logic [ADDR_W:0]   fifo_level;
    logic [5:0]        bits_pending;
    logic              overflow;

    int n_checks = 0;
    int n_pass   = 0;
    logic [WORD_W-1:0] exp_q [$];

    typedef struct {
        logic [WORD_W-1:0] pattern;
        logic [WORD_W-1:0] exp_data;
    } vec_t;
    vec_t vecs [4];

    logic [WORD_W-1:0] w [6];

    always #5 clk = ~clk;

    // External shift register: MSB-first bits enter at the LSB on each strobe.
    always @(posedge clk or posedge rst) begin
        if (rst) shift_reg <= '0;
        else if (processed_bit_valid) shift_reg <= {shift_reg[WORD_W-2:0], bit_in};
    end

    trng_word_reader #(
        .WORD_W(WORD_W), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .processed_bit_valid(processed_bit_valid), .shift_reg(shift_reg),
        .rd_ready(rd_ready), .clear_overflow(clear_overflow),
        .rd_valid(rd_valid), .rd_data(rd_data), .fifo_level(fifo_level),
        .bits_pending(bits_pending), .overflow(overflow)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_bits(input logic [WORD_W-1:0] pattern, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            processed_bit_valid = 1'b1;
            bit_in = pattern[i];
            tick();
        end
        processed_bit_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        rd_ready = 1'b1;
        while (exp_q.size() != 0 && k < 40) begin
            tick();
            k++;
        end
        check({name, "_all_words_seen"}, exp_q.size(), 0);
        repeat (3) tick();
        @(negedge clk);
        check({name, "_empty_valid"}, rd_valid, 0);
        check({name, "_empty_level"}, fifo_level, 0);
        tick();
        rd_ready = 1'b0;
    endtask

    // Scoreboard: every accepted word must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_word: got 0x%08h expected none", rd_data);
            end else begin
                check("pop_order", rd_data, exp_q[0]);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'hA5A5_1234, 32'hA5A5_1234};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[2] = '{32'h0000_0001, 32'h0000_0001};
        vecs[3] = '{32'h8000_0000, 32'h8000_0000};

        // Reset state
        repeat (2) tick();
        @(negedge clk);
        check("rst_valid", rd_valid, 0);
        check("rst_data", rd_data, 0);
        check("rst_level", fifo_level, 0);
        check("rst_pending", bits_pending, 0);
        check("rst_overflow", overflow, 0);
        tick();
        rst = 1'b0;
        enable = 1'b1;
        tick();

        // Single-word latency: valid two cycles after the 32nd strobe, one cycle long
        rd_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            send_bits(vecs[v].pattern, 32);
            exp_q.push_back(vecs[v].exp_data);
            @(negedge clk);
            check("lat_n1_valid", rd_valid, 0);
            check("lat_n1_pending", bits_pending, 0);
            tick();
            @(negedge clk);
            check("lat_n2_valid", rd_valid, 1);
            check("lat_n2_data", rd_data, vecs[v].exp_data);
            check("lat_n2_level", fifo_level, 1);
            tick();
            @(negedge clk);
            check("lat_n3_valid", rd_valid, 0);
            tick();
        end
        check("table_all_seen", exp_q.size(), 0);

        // Saturation and overflow, with a drop beating a same-cycle clear
        rd_ready = 1'b0;
        for (int i = 0; i < 6; i++) w[i] = $urandom;
        for (int i = 0; i < 4; i++) begin
            send_bits(w[i], 32);
            exp_q.push_back(w[i]);
        end
        tick(); tick();
        @(negedge clk);
        check("full_level", fifo_level, 4);
        check("full_no_ovf", overflow, 0);
        check("full_head_stable", rd_data, w[0]);
        send_bits(w[4], 32);
        tick();
        @(negedge clk);
        check("ovf_set", overflow, 1);
        check("ovf_level", fifo_level, 4);
        check("ovf_head", rd_data, w[0]);
        send_bits(w[5], 32);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        @(negedge clk);
        check("drop_beats_clear", overflow, 1);
        drain("ovf_drain");
        check("ovf_sticky", overflow, 1);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        @(negedge clk);
        check("ovf_cleared", overflow, 0);
        tick();

        // Full FIFO with a pop in the capture cycle: push and pop both succeed
        for (int i = 0; i < 5; i++) w[i] = $urandom;
        for (int i = 0; i < 4; i++) begin
            send_bits(w[i], 32);
            exp_q.push_back(w[i]);
        end
        send_bits(w[4], 32);
        exp_q.push_back(w[4]);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        @(negedge clk);
        check("pushpop_level", fifo_level, 4);
        check("pushpop_no_ovf", overflow, 0);
        check("pushpop_new_head", rd_data, w[1]);
        drain("pushpop_drain");

        // Partial word discarded by enable=0; pending capture still completes
        rd_ready = 1'b1;
        send_bits($urandom, 20);
        @(negedge clk);
        check("partial_pending", bits_pending, 20);
        enable = 1'b0;
        tick();
        @(negedge clk);
        check("disable_clears", bits_pending, 0);
        tick(); tick();
        enable = 1'b1;
        w[0] = $urandom;
        send_bits(w[0], 31);
        @(negedge clk);
        check("reenable_31", bits_pending, 31);
        check("reenable_no_word", rd_valid, 0);
        send_bits(w[0], 1);
        w[0] = {w[0][30:0], w[0][0]};
        exp_q.push_back(shift_reg);
        enable = 1'b0;
        tick();
        @(negedge clk);
        check("capture_survives_disable", fifo_level + {2'b0, rd_valid}, 2);
        enable = 1'b1;
        drain("enable_drain");

        // Back-to-back words: capture-cycle strobe is bit 1 of word 2
        w[0] = $urandom;
        w[1] = $urandom;
        rd_ready = 1'b1;
        send_bits(w[0], 32);
        exp_q.push_back(w[0]);
        send_bits(w[1], 32);
        exp_q.push_back(w[1]);
        @(negedge clk);
        check("b2b_pending", bits_pending, 0);
        drain("b2b_drain");

        // Asynchronous reset with buffered words and a partial word
        w[0] = $urandom;
        w[1] = $urandom;
        rd_ready = 1'b0;
        send_bits(w[0], 32);
        exp_q.push_back(w[0]);
        send_bits(w[1], 32);
        exp_q.push_back(w[1]);
        send_bits($urandom, 17);
        @(negedge clk);
        check("prerst_level", fifo_level, 2);
        check("prerst_pending", bits_pending, 17);
        #1 rst = 1'b1;
        #1;
        check("async_valid", rd_valid, 0);
        check("async_data", rd_data, 0);
        check("async_level", fifo_level, 0);
        check("async_pending", bits_pending, 0);
        check("async_overflow", overflow, 0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        rd_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("no_stale_valid", rd_valid, 0);
        check("no_stale_level", fifo_level, 0);
        tick();
        w[2] = $urandom;
        send_bits(w[2], 32);
        exp_q.push_back(w[2]);
        drain("post_rst_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
